// File: rtl/lb_resp_pkg.sv
// Shared types and constants for the localbus register file responder.
package lb_resp_pkg;

    typedef enum logic [1:0] {
        CTRL,
        STAT,
        ILLEGAL
    } addr_class_e;

    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;
    localparam int          ERRCNT_W  = 16;

endpackage

// File: rtl/lb_regfile_resp_if.sv
// Localbus write/read strobe bundle between a bus master and the register file.
interface lb_regfile_resp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) ();
    logic                  wren;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rden;
    logic                  rdenlast;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  rvalid;
    logic                  rvalidlast;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output wren, waddr, wdata, rden, rdenlast, raddr,
        input  rvalid, rvalidlast, rdata
    );

    modport slave (
        input  wren, waddr, wdata, rden, rdenlast, raddr,
        output rvalid, rvalidlast, rdata
    );
endinterface

// File: rtl/lb_rdpipe.sv
// Fixed-length delay line for read valid/last/data; data is zeroed whenever valid is low.
module lb_rdpipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vld_in,
    input  logic                  last_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  vld_out,
    output logic                  last_out,
    output logic [DATA_WIDTH-1:0] data_out
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign vld_out  = vld_in;
            assign last_out = last_in;
            assign data_out = vld_in ? data_in : '0;
        end else begin : g_stages
            logic [STAGES-1:0]                 vld_p;
            logic [STAGES-1:0]                 last_p;
            logic [STAGES-1:0][DATA_WIDTH-1:0] data_p;

            // Control bits are flushed by reset; the data word is gated on the way out instead.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_p  <= '0;
                    last_p <= '0;
                end else begin
                    vld_p[0]  <= vld_in;
                    last_p[0] <= last_in;
                    for (int i = 1; i < STAGES; i++) begin
                        vld_p[i]  <= vld_p[i-1];
                        last_p[i] <= last_p[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                data_p[0] <= data_in;
                for (int i = 1; i < STAGES; i++) begin
                    data_p[i] <= data_p[i-1];
                end
            end

            assign vld_out  = vld_p[STAGES-1];
            assign last_out = last_p[STAGES-1];
            assign data_out = vld_p[STAGES-1] ? data_p[STAGES-1] : '0;
        end
    endgenerate

endmodule

// File: rtl/lb_regfile_resp.sv
// Localbus register file: RW control registers, RO status words, fixed-latency reads, error counter.
module lb_regfile_resp
    import lb_resp_pkg::*;
#(
    parameter int                              DATA_WIDTH = 32,
    parameter int                              ADDR_WIDTH = 12,
    parameter int                              NREG       = 16,
    parameter int                              NSTAT      = 16,
    parameter int                              READDELAY  = 3,
    parameter logic [NREG*DATA_WIDTH-1:0]      CTRL_INIT  = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    lb_regfile_resp_if.slave             bus,
    output logic [NREG*DATA_WIDTH-1:0]   ctrl,
    output logic [NREG-1:0]              ctrl_wstb,
    input  logic [NSTAT*DATA_WIDTH-1:0]  stat,
    output logic [ERRCNT_W-1:0]          errcnt
);

    localparam int SUM_W = ERRCNT_W + 1;

    function automatic addr_class_e decode(input logic [ADDR_WIDTH-1:0] a);
        logic [63:0] ax;
        ax = 64'(a);
        if (ax < 64'(NREG))              return CTRL;
        else if (ax < 64'(NREG + NSTAT)) return STAT;
        else                             return ILLEGAL;
    endfunction

    logic [NREG-1:0][DATA_WIDTH-1:0] ctrl_q;
    logic [NREG-1:0]                 wr_hit;
    addr_class_e                     wcls;
    addr_class_e                     rcls;
    logic                            wr_err;
    logic                            rd_err;
    logic [SUM_W-1:0]                err_sum;
    logic [DATA_WIDTH-1:0]           rd_word;
    logic                            vld_p0;
    logic                            last_p0;
    logic [DATA_WIDTH-1:0]           data_p0;

    assign wcls   = decode(bus.waddr);
    assign rcls   = decode(bus.raddr);
    assign wr_err = bus.wren && (wcls != CTRL);
    assign rd_err = bus.rden && (rcls == ILLEGAL);

    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NREG; i++) begin
            wr_hit[i] = bus.wren && (bus.waddr == ADDR_WIDTH'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= CTRL_INIT;
            ctrl_wstb <= '0;
        end else begin
            ctrl_wstb <= wr_hit;
            for (int i = 0; i < NREG; i++) begin
                if (wr_hit[i]) ctrl_q[i] <= bus.wdata;
            end
        end
    end

    assign ctrl = ctrl_q;

    // Two errors can land in one cycle, so the sum is one bit wider and clamps on overflow.
    assign err_sum = SUM_W'(errcnt) + SUM_W'(wr_err) + SUM_W'(rd_err);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) errcnt <= '0;
        else       errcnt <= err_sum[ERRCNT_W] ? '1 : err_sum[ERRCNT_W-1:0];
    end

    // Read mux samples ctrl before this cycle's write lands, giving read-before-write on collisions.
    always_comb begin
        rd_word = '0;
        case (rcls)
            CTRL: begin
                for (int i = 0; i < NREG; i++) begin
                    if (bus.raddr == ADDR_WIDTH'(i)) rd_word = ctrl_q[i];
                end
            end
            STAT: begin
                for (int j = 0; j < NSTAT; j++) begin
                    if (bus.raddr == ADDR_WIDTH'(NREG + j)) rd_word = stat[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            default: rd_word = DATA_WIDTH'(DEAD_BEEF);
        endcase
    end

    // Stage p0: capture the addressed word in the rden cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else begin
            vld_p0  <= bus.rden;
            last_p0 <= bus.rden && bus.rdenlast;
        end
    end

    always_ff @(posedge clk) begin
        data_p0 <= rd_word;
    end

    lb_rdpipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (READDELAY - 1)
    ) u_rdpipe (
        .clk      (clk),
        .reset    (reset),
        .vld_in   (vld_p0),
        .last_in  (last_p0),
        .data_in  (data_p0),
        .vld_out  (bus.rvalid),
        .last_out (bus.rvalidlast),
        .data_out (bus.rdata)
    );

endmodule

// File: tb/tb_lb_regfile_resp.sv
// Randomized and directed bench for lb_regfile_resp against a transaction-level model.
module tb_lb_regfile_resp;
    import lb_resp_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int NREG  = 16;
    localparam int NSTAT = 16;
    localparam int RD    = 3;

    function automatic logic [NREG*DW-1:0] make_init();
        logic [NREG*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            if (i != 5) v[i*DW +: DW] = 32'hC000_0000 | i;
        end
        return v;
    endfunction

    localparam logic [NREG*DW-1:0] INIT = make_init();

    typedef struct {
        bit          v;
        bit          l;
        logic [31:0] d;
    } rd_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREG*DW-1:0]    ctrl;
    logic [NREG-1:0]       ctrl_wstb;
    logic [NSTAT*DW-1:0]   stat_v;
    logic [15:0]           errcnt;

    logic [31:0]           m_ctrl [NREG];
    int                    m_err;
    logic [NREG-1:0]       m_wstb;
    rd_t                   q[$];

    int n_chk = 0;
    int n_err = 0;

    lb_regfile_resp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    lb_regfile_resp #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NREG       (NREG),
        .NSTAT      (NSTAT),
        .READDELAY  (RD),
        .CTRL_INIT  (INIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ctrl      (ctrl),
        .ctrl_wstb (ctrl_wstb),
        .stat      (stat_v),
        .errcnt    (errcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        rd_t idle;
        idle = '{v: 1'b0, l: 1'b0, d: 32'h0};
        for (int i = 0; i < NREG; i++) m_ctrl[i] = INIT[i*DW +: DW];
        m_err  = 0;
        m_wstb = '0;
        q.delete();
        for (int i = 0; i < RD - 1; i++) q.push_back(idle);
    endtask

    function automatic logic [NREG*DW-1:0] model_ctrl();
        logic [NREG*DW-1:0] v;
        for (int i = 0; i < NREG; i++) v[i*DW +: DW] = m_ctrl[i];
        return v;
    endfunction

    task automatic bus_idle();
        bus.wren = 1'b0; bus.waddr = '0; bus.wdata = '0;
        bus.rden = 1'b0; bus.rdenlast = 1'b0; bus.raddr = '0;
    endtask

    // Apply one bus cycle starting at a falling edge; check all outputs at the next falling edge.
    task automatic step(input bit we, input int wa, input logic [31:0] wd,
                        input bit re, input bit rl, input int ra);
        rd_t r;
        rd_t e;
        bus.wren = we; bus.waddr = AW'(wa); bus.wdata = wd;
        bus.rden = re; bus.rdenlast = rl; bus.raddr = AW'(ra);
        r = '{v: 1'b0, l: 1'b0, d: 32'h0};
        if (re) begin
            r.v = 1'b1;
            r.l = rl;
            if (ra < NREG)              r.d = m_ctrl[ra];
            else if (ra < NREG + NSTAT) r.d = stat_v[(ra-NREG)*DW +: DW];
            else begin
                r.d = DEAD_BEEF;
                m_err++;
            end
        end
        m_wstb = '0;
        if (we) begin
            if (wa < NREG) begin
                m_ctrl[wa] = wd;
                m_wstb[wa] = 1'b1;
            end else begin
                m_err++;
            end
        end
        if (m_err > 65535) m_err = 65535;
        q.push_back(r);
        @(posedge clk);
        @(negedge clk);
        e = q.pop_front();
        chk("rvalid", bus.rvalid, e.v);
        chk("rvalidlast", bus.rvalidlast, e.l);
        chk("rdata", bus.rdata, e.d);
        chk("ctrl_wstb", ctrl_wstb, m_wstb);
        chk("ctrl", ctrl, model_ctrl());
        chk("errcnt", errcnt, m_err);
    endtask

    task automatic idle_step();
        step(0, 0, 32'h0, 0, 0, 0);
    endtask

    initial begin
        int wa, ra, si;
        bus_idle();
        stat_v = '0;
        reset  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_rvalidlast", bus.rvalidlast, 1'b0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_ctrl", ctrl, INIT);
        chk("rst_wstb", ctrl_wstb, 16'h0);
        chk("rst_errcnt", errcnt, 16'h0);
        reset = 1'b0;
        model_reset();

        // Single control write and its one-cycle strobe
        step(1, 3, 32'h1234_5678, 0, 0, 0);
        chk("wr3_wstb", ctrl_wstb, 16'h0008);
        chk("wr3_ctrl", ctrl[3*DW +: DW], 32'h1234_5678);
        idle_step();
        chk("wr3_wstb_clr", ctrl_wstb, 16'h0000);

        // Burst read 0..3, last on the fourth word
        for (int a = 0; a < 4; a++) step(0, 0, 32'h0, 1, (a == 3), a);
        repeat (RD) idle_step();

        // Status read, then rejected write to the same status word
        stat_v[2*DW +: DW] = 32'hA5A5_0001;
        step(0, 0, 32'h0, 1, 0, NREG + 2);
        idle_step();
        idle_step();
        chk("stat2_rdata", bus.rdata, 32'hA5A5_0001);
        step(1, NREG + 2, 32'hFFFF_FFFF, 0, 0, 0);
        chk("stat_wr_err", errcnt, 16'd1);
        chk("stat_wr_ctrl", ctrl, model_ctrl());

        // Illegal read, then simultaneous illegal write and read
        step(0, 0, 32'h0, 1, 0, 12'h800);
        idle_step();
        idle_step();
        chk("ill_rdata", bus.rdata, 32'hDEAD_BEEF);
        chk("ill_err", errcnt, 16'd2);
        step(1, 12'h800, 32'h5, 1, 0, 12'h801);
        chk("ill_dual_err", errcnt, 16'd4);
        repeat (RD) idle_step();

        // Same-cycle write and read of register 5
        step(1, 5, 32'h1, 1, 0, 5);
        idle_step();
        idle_step();
        chk("rbw_old", bus.rdata, 32'h0);
        step(0, 0, 32'h0, 1, 0, 5);
        idle_step();
        idle_step();
        chk("rbw_new", bus.rdata, 32'h1);

        // rdenlast without rden must not produce anything
        step(0, 0, 32'h0, 0, 1, 0);
        repeat (RD) idle_step();

        for (int n = 0; n < 400; n++) begin
            si = $urandom_range(0, NSTAT - 1);
            stat_v[si*DW +: DW] = $urandom();
            wa = ($urandom_range(0, 7) == 0) ? $urandom_range(32, 4095) : $urandom_range(0, 31);
            ra = ($urandom_range(0, 7) == 0) ? $urandom_range(32, 4095) : $urandom_range(0, 31);
            step($urandom_range(0, 1), wa, $urandom(), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1), ra);
        end
        repeat (RD) idle_step();

        // Reset one cycle after a read: the read must never surface
        step(1, 7, 32'hABCD_0000, 1, 1, 2);
        bus_idle();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_rvalid", bus.rvalid, 1'b0);
        chk("midrst_ctrl", ctrl, INIT);
        chk("midrst_errcnt", errcnt, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (RD + 1) idle_step();

        // Drive the counter to 0xFFFE with paired errors, then confirm it saturates
        while (m_err < 16'hFFFE) step(1, 12'h800, 32'h0, 1, 0, 12'hFFF);
        chk("err_fffe", errcnt, 16'hFFFE);
        step(1, 12'h800, 32'h0, 1, 0, 12'hFFF);
        chk("err_sat", errcnt, 16'hFFFF);
        step(1, 12'h800, 32'h0, 1, 0, 12'hFFF);
        chk("err_hold", errcnt, 16'hFFFF);
        repeat (RD) idle_step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
